// File: rtl/md_unit_if.sv
// md_unit_if: E-stage connection between the pipeline and the multiply/divide unit.
//   mdop     - E-stage md operation code (0 none, 1 mult, 2 multu, 3 div, 4 divu,
//              5 mfhi, 6 mflo, 7 mthi, 8 mtlo, others none)
//   a, b     - forwarded rs/rt operand values
//   e_valid  - E-stage slot holds a real instruction
//   d_is_md  - D-stage instruction is an md-class op
//   start    - an mult/div operation is launched this cycle
//   busy     - an operation is in flight
//   md_out   - HI/LO read data for mfhi/mflo
//   md_stall - hold the D-stage md-class instruction
interface md_unit_if;
  logic [3:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        e_valid;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic [31:0] md_out;
  logic        md_stall;

  // Pipeline side: drives the operation, observes unit status
  modport master (
    output mdop, a, b, e_valid, d_is_md,
    input  start, busy, md_out, md_stall
  );

  // Unit side
  modport slave (
    input  mdop, a, b, e_valid, d_is_md,
    output start, busy, md_out, md_stall
  );
endinterface

// File: rtl/md_unit.sv
// md_unit: HI/LO registers and multi-cycle mult/multu/div/divu sequencer for the
// E stage of the pipelined MIPS core. Serves mfhi/mflo/mthi/mtlo and requests a
// D-stage stall for md-class instructions while an operation is in flight.
//   clk   - system clock
//   reset - synchronous, active-high reset
//   bus   - md_unit_if.slave (mdop, a, b, e_valid, d_is_md in; start, busy,
//           md_out, md_stall out)
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic     clk,
  input  logic     reset,
  md_unit_if.slave bus
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [31:0] MULT_LOAD = 32'(MULT_CYCLES);
  localparam logic [31:0] DIV_LOAD  = 32'(DIV_CYCLES);

  logic [0:0]  state;
  logic [31:0] counter;
  logic        busy_q;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] pend_hi;
  logic [31:0] pend_lo;

  logic        is_muldiv;
  logic        start;
  logic [63:0] result;
  logic [31:0] load_val;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic        [31:0] divisor;
  logic signed [31:0] quot_s;
  logic signed [31:0] rem_s;
  logic        [31:0] quot_u;
  logic        [31:0] rem_u;
  logic               div_ovf;

  assign is_muldiv = (bus.mdop >= 4'd1) && (bus.mdop <= 4'd4);
  assign start     = bus.e_valid && is_muldiv && (state == ST_IDLE);
  assign load_val  = (bus.mdop <= 4'd2) ? MULT_LOAD : DIV_LOAD;

  // Divisor forced non-zero so the dividers never see zero; the zero case is
  // handled separately by keeping the old HI/LO.
  assign divisor = (bus.b == 32'd0) ? 32'd1 : bus.b;
  assign div_ovf = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);

  assign prod_s = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
  assign prod_u = {32'd0, bus.a} * {32'd0, bus.b};
  assign quot_s = $signed(bus.a) / $signed(divisor);
  assign rem_s  = $signed(bus.a) % $signed(divisor);
  assign quot_u = bus.a / divisor;
  assign rem_u  = bus.a % divisor;

  // Result captured at launch; divide by zero keeps the pre-op HI/LO and the
  // overflowing signed divide is pinned to the architectural answer.
  always_comb begin
    result = {hi, lo};
    case (bus.mdop)
      4'd1: result = prod_s;
      4'd2: result = prod_u;
      4'd3: begin
        if (bus.b == 32'd0)
          result = {hi, lo};
        else if (div_ovf)
          result = {32'd0, 32'h8000_0000};
        else
          result = {rem_s, quot_s};
      end
      4'd4: begin
        if (bus.b != 32'd0)
          result = {rem_u, quot_u};
      end
      default: result = {hi, lo};
    endcase
  end

  // Sequencer: launch from IDLE, count down in BUSY, commit HI/LO on the last edge
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      counter <= 32'd0;
      busy_q  <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            pend_hi <= result[63:32];
            pend_lo <= result[31:0];
            counter <= load_val;
            busy_q  <= 1'b1;
            state   <= ST_BUSY;
          end else if (bus.e_valid && bus.mdop == 4'd7) begin
            hi <= bus.a;
          end else if (bus.e_valid && bus.mdop == 4'd8) begin
            lo <= bus.a;
          end
        end
        default: begin
          counter <= counter - 32'd1;
          if (counter == 32'd1) begin
            hi     <= pend_hi;
            lo     <= pend_lo;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign bus.start    = start;
  assign bus.busy     = busy_q;
  assign bus.md_stall = bus.d_is_md && (start || busy_q);

  // Reads are only meaningful for a real E-stage mfhi/mflo
  always_comb begin
    bus.md_out = 32'd0;
    if (bus.e_valid && bus.mdop == 4'd5)
      bus.md_out = hi;
    else if (bus.e_valid && bus.mdop == 4'd6)
      bus.md_out = lo;
  end

endmodule
